// File: rtl/fetch_stage_if.sv
// Fetch-side bundle: ibus read channel, stall/redirect inputs and the registered fetch->decode word.
// master = fetch stage, slave = memory/decode/execute side.
interface fetch_stage_if #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
);
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] raw_instr;
    } fetch_data_t;

    logic            ireq_valid;
    logic [XLEN-1:0] ireq_addr;
    logic            iresp_data_ok;
    logic [ILEN-1:0] iresp_data;
    logic            stall;
    logic            branch;
    logic [XLEN-1:0] branch_target;
    fetch_data_t     dataF;

    modport master (
        output ireq_valid, ireq_addr, dataF,
        input  iresp_data_ok, iresp_data, stall, branch, branch_target
    );

    modport slave (
        input  ireq_valid, ireq_addr, dataF,
        output iresp_data_ok, iresp_data, stall, branch, branch_target
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: one ibus read in flight, response registered into dataF one cycle later (1 instr/cycle on a 0-wait bus).
// Stall holds dataF bit-identical and parks a late response in a buffer; branch bubbles dataF and redirects the PC.
module fetch_stage #(
    parameter int              XLEN     = 64,
    parameter int              ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000)
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master io_fetch
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_HOLD  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [XLEN-1:0] r_req_pc;
    logic [XLEN-1:0] r_redir_pc;
    logic [ILEN-1:0] r_buf_instr;
    logic            r_dataF_valid;
    logic [XLEN-1:0] r_dataF_pc;
    logic [ILEN-1:0] r_dataF_raw_instr;

    logic [XLEN-1:0] w_req_pc_nxt;
    logic [XLEN-1:0] w_redir_pc_nxt;
    logic [ILEN-1:0] w_buf_instr_nxt;
    logic            w_dataF_valid_nxt;
    logic [XLEN-1:0] w_dataF_pc_nxt;
    logic [ILEN-1:0] w_dataF_raw_instr_nxt;

    logic            w_data_ok;
    logic            w_stall;
    logic            w_branch;
    logic [XLEN-1:0] w_branch_target;
    logic [XLEN-1:0] w_req_pc_inc;

    assign w_data_ok       = io_fetch.iresp_data_ok;
    assign w_stall         = io_fetch.stall;
    assign w_branch        = io_fetch.branch;
    assign w_branch_target = io_fetch.branch_target;
    assign w_req_pc_inc    = r_req_pc + XLEN'(4);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt           = r_state;
        w_req_pc_nxt          = r_req_pc;
        w_redir_pc_nxt        = r_redir_pc;
        w_buf_instr_nxt       = r_buf_instr;
        w_dataF_valid_nxt     = r_dataF_valid;
        w_dataF_pc_nxt        = r_dataF_pc;
        w_dataF_raw_instr_nxt = r_dataF_raw_instr;

        case (r_state)
            S_REQ: begin
                if (w_branch) begin
                    w_dataF_valid_nxt = 1'b0;
                    if (w_data_ok) begin
                        w_req_pc_nxt = w_branch_target;
                    end else begin
                        // The stale read cannot be abandoned, so keep its address on the bus and park the target.
                        w_redir_pc_nxt = w_branch_target;
                        w_state_nxt    = S_FLUSH;
                    end
                end else if (w_data_ok) begin
                    if (!w_stall) begin
                        w_dataF_valid_nxt     = 1'b1;
                        w_dataF_pc_nxt        = r_req_pc;
                        w_dataF_raw_instr_nxt = io_fetch.iresp_data;
                        w_req_pc_nxt          = w_req_pc_inc;
                    end else begin
                        w_buf_instr_nxt = io_fetch.iresp_data;
                        w_state_nxt     = S_HOLD;
                    end
                end else if (!w_stall) begin
                    w_dataF_valid_nxt = 1'b0;
                end
            end

            S_HOLD: begin
                if (w_branch) begin
                    w_dataF_valid_nxt = 1'b0;
                    w_req_pc_nxt      = w_branch_target;
                    w_state_nxt       = S_REQ;
                end else if (!w_stall) begin
                    w_dataF_valid_nxt     = 1'b1;
                    w_dataF_pc_nxt        = r_req_pc;
                    w_dataF_raw_instr_nxt = r_buf_instr;
                    w_req_pc_nxt          = w_req_pc_inc;
                    w_state_nxt           = S_REQ;
                end
            end

            S_FLUSH: begin
                w_dataF_valid_nxt = 1'b0;
                if (w_branch) begin
                    w_redir_pc_nxt = w_branch_target;
                end
                if (w_data_ok) begin
                    w_req_pc_nxt = w_branch ? w_branch_target : r_redir_pc;
                    w_state_nxt  = S_REQ;
                end
            end

            default: begin
                w_state_nxt = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_pc          <= RESET_PC;
            r_redir_pc        <= '0;
            r_buf_instr       <= '0;
            r_dataF_valid     <= 1'b0;
            r_dataF_pc        <= '0;
            r_dataF_raw_instr <= '0;
        end else begin
            r_req_pc          <= w_req_pc_nxt;
            r_redir_pc        <= w_redir_pc_nxt;
            r_buf_instr       <= w_buf_instr_nxt;
            r_dataF_valid     <= w_dataF_valid_nxt;
            r_dataF_pc        <= w_dataF_pc_nxt;
            r_dataF_raw_instr <= w_dataF_raw_instr_nxt;
        end
    end

    assign io_fetch.ireq_valid = (r_state == S_REQ) || (r_state == S_FLUSH);
    assign io_fetch.ireq_addr  = r_req_pc;
    assign io_fetch.dataF      = {r_dataF_valid, r_dataF_pc, r_dataF_raw_instr};

    // An accepted-but-unanswered read must keep its address until the response strobe.
    a_req_stable: assert property (@(posedge clk) disable iff (reset)
        io_fetch.ireq_valid && !io_fetch.iresp_data_ok |=> io_fetch.ireq_valid && $stable(io_fetch.ireq_addr));

    a_dataF_hold: assert property (@(posedge clk) disable iff (reset)
        r_dataF_valid && w_stall && !w_branch |=> $stable(io_fetch.dataF));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed protocol scenarios, then random bus/stall/branch traffic scored against a program-order model.
module tb_fetch_stage;
    localparam logic [63:0] RST_PC = 64'h8000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_stage_if #(.XLEN(64), .ILEN(32)) bus ();

    fetch_stage #(.XLEN(64), .ILEN(32), .RESET_PC(RST_PC)) dut (
        .clk      (clk),
        .reset    (reset),
        .io_fetch (bus)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb_q[$];
    exp_t        sb_e;
    bit          rnd_on = 1'b0;
    logic [63:0] want_pc;
    bit          stale;
    bit          prev_hold = 1'b0;
    logic [96:0] prev_df;

    // Memory image: every address holds a distinct, address-derived word.
    function automatic logic [31:0] ifn(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_df(input string name, input logic [63:0] pc, input logic [31:0] ins);
        chk({name, ".valid"}, 64'(bus.dataF.valid), 64'd1);
        chk({name, ".pc"}, bus.dataF.pc, pc);
        chk({name, ".instr"}, 64'(bus.dataF.raw_instr), 64'(ins));
    endtask

    task automatic chk_bubble(input string name);
        chk({name, ".valid"}, 64'(bus.dataF.valid), 64'd0);
    endtask

    task automatic chk_addr(input string name, input logic [63:0] addr);
        chk({name, ".ireq_valid"}, 64'(bus.ireq_valid), 64'd1);
        chk({name, ".ireq_addr"}, bus.ireq_addr, addr);
    endtask

    task automatic chk_reset(input string name);
        chk({name, ".valid"}, 64'(bus.dataF.valid), 64'd0);
        chk({name, ".pc"}, bus.dataF.pc, 64'd0);
        chk({name, ".instr"}, 64'(bus.dataF.raw_instr), 64'd0);
        chk_addr(name, RST_PC);
    endtask

    // Bus responds only to a presented request, always with the word at the presented address.
    task automatic drive(input bit ok, input bit st, input bit br, input logic [63:0] tgt);
        @(posedge clk);
        #1;
        bus.iresp_data_ok = ok && bus.ireq_valid;
        bus.iresp_data    = ifn(bus.ireq_addr);
        bus.stall         = st;
        bus.branch        = br;
        bus.branch_target = tgt;
        @(negedge clk);
    endtask

    // Program-order model: a response is useful only if it is not stale and no redirect happens with it.
    task automatic model_step(input bit br, input logic [63:0] tgt);
        if (bus.ireq_valid && !stale) chk("req.addr", bus.ireq_addr, want_pc);
        if (bus.iresp_data_ok) begin
            if (br || stale) begin
                stale = 1'b0;
            end else begin
                sb_q.push_back('{want_pc, ifn(want_pc)});
                want_pc = want_pc + 64'd4;
            end
        end
        if (br) begin
            sb_q.delete();
            want_pc = tgt;
            stale   = bus.ireq_valid && !bus.iresp_data_ok;
        end
    endtask

    always @(negedge clk) begin
        if (rnd_on) begin
            if (prev_hold) begin
                chk("hold.pc", bus.dataF.pc, prev_df[95:32]);
                chk("hold.instr", 64'(bus.dataF.raw_instr), 64'(prev_df[31:0]));
                chk("hold.valid", 64'(bus.dataF.valid), 64'(prev_df[96]));
            end
            if (bus.dataF.valid && !bus.stall && !bus.branch) begin
                chk("sb.avail", 64'(sb_q.size() > 0), 64'd1);
                if (sb_q.size() > 0) begin
                    sb_e = sb_q.pop_front();
                    chk("sb.pc", bus.dataF.pc, sb_e.pc);
                    chk("sb.instr", 64'(bus.dataF.raw_instr), 64'(sb_e.instr));
                end
            end
            prev_hold = bus.dataF.valid && bus.stall && !bus.branch && !reset;
            prev_df   = bus.dataF;
        end else begin
            prev_hold = 1'b0;
        end
    end

    initial begin
        reset             = 1'b1;
        bus.iresp_data_ok = 1'b0;
        bus.iresp_data    = '0;
        bus.stall         = 1'b0;
        bus.branch        = 1'b0;
        bus.branch_target = '0;

        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk_reset("rst");
        reset = 1'b0;

        // Zero-wait streaming from RESET_PC.
        drive(1, 0, 0, 0);
        chk_addr("t1.c0", RST_PC);
        chk_bubble("t1.c0");
        drive(1, 0, 0, 0);
        chk_addr("t1.c1", RST_PC + 64'h4);
        chk_df("t1.c1", RST_PC, ifn(RST_PC));
        drive(1, 0, 0, 0);
        chk_addr("t1.c2", RST_PC + 64'h8);
        chk_df("t1.c2", RST_PC + 64'h4, ifn(RST_PC + 64'h4));

        // Response lands during stall: parked, dataF frozen, request withdrawn.
        drive(1, 1, 0, 0);
        bus.iresp_data = 32'h0050_0093;
        chk_addr("t2.resp", RST_PC + 64'hC);
        chk_df("t2.resp", RST_PC + 64'h8, ifn(RST_PC + 64'h8));
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 0);
            chk("t2.stall.ireq_valid", 64'(bus.ireq_valid), 64'd0);
            chk_df("t2.stall", RST_PC + 64'h8, ifn(RST_PC + 64'h8));
        end
        drive(0, 0, 0, 0);
        chk("t2.rel.ireq_valid", 64'(bus.ireq_valid), 64'd0);
        chk_df("t2.rel", RST_PC + 64'h8, ifn(RST_PC + 64'h8));

        // Branch with the request to +0x10 outstanding; response 2 cycles later is discarded.
        drive(0, 0, 1, RST_PC + 64'h100);
        chk_df("t2.out", RST_PC + 64'hC, 32'h0050_0093);
        chk_addr("t3.br", RST_PC + 64'h10);
        drive(0, 0, 0, 0);
        chk_addr("t3.f0", RST_PC + 64'h10);
        chk_bubble("t3.f0");
        drive(1, 0, 0, 0);
        chk_addr("t3.f1", RST_PC + 64'h10);
        chk_bubble("t3.f1");
        drive(0, 0, 0, 0);
        chk_addr("t3.redir", RST_PC + 64'h100);
        chk_bubble("t3.redir");

        // Branch coincident with the response: no flush, target on the bus next cycle.
        drive(1, 0, 1, RST_PC + 64'h200);
        chk_addr("t4.br", RST_PC + 64'h100);
        drive(0, 0, 0, 0);
        chk_addr("t4.redir", RST_PC + 64'h200);
        chk_bubble("t4.redir");
        drive(1, 0, 0, 0);
        chk_addr("t4.fetch", RST_PC + 64'h200);

        // Two branches while flushing: only the second target is fetched.
        drive(0, 0, 1, RST_PC + 64'h300);
        chk_df("t4.out", RST_PC + 64'h200, ifn(RST_PC + 64'h200));
        chk_addr("t5.brA", RST_PC + 64'h204);
        drive(0, 0, 1, RST_PC + 64'h400);
        chk_addr("t5.brB", RST_PC + 64'h204);
        chk_bubble("t5.brB");
        drive(1, 0, 0, 0);
        chk_addr("t5.stale", RST_PC + 64'h204);
        chk_bubble("t5.stale");
        drive(1, 0, 0, 0);
        chk_addr("t5.redir", RST_PC + 64'h400);
        chk_bubble("t5.redir");
        drive(0, 0, 0, 0);
        chk_df("t5.out", RST_PC + 64'h400, ifn(RST_PC + 64'h400));
        chk_addr("t5.next", RST_PC + 64'h404);

        // Reset while parked in HOLD.
        drive(1, 1, 0, 0);
        drive(0, 1, 0, 0);
        chk("t6.hold.ireq_valid", 64'(bus.ireq_valid), 64'd0);
        reset = 1'b1;
        drive(0, 0, 0, 0);
        chk_reset("t6.hold.rst");
        reset = 1'b0;

        // Reset while flushing, with the stale response arriving in the reset cycle.
        drive(0, 0, 1, RST_PC + 64'h500);
        chk_addr("t6.pre", RST_PC);
        drive(1, 0, 0, 0);
        chk_addr("t6.flush", RST_PC);
        reset = 1'b1;
        drive(0, 0, 0, 0);
        chk_reset("t6.flush.rst");
        reset = 1'b0;
        drive(1, 0, 0, 0);
        chk_addr("t6.restart", RST_PC);

        // Redirect to the top of the address space; the PC wraps to zero.
        drive(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        chk_df("t6.out", RST_PC, ifn(RST_PC));
        chk_addr("wrap.br", RST_PC + 64'h4);
        drive(1, 0, 0, 0);
        chk_addr("wrap.stale", RST_PC + 64'h4);
        chk_bubble("wrap.stale");
        drive(1, 0, 0, 0);
        chk_addr("wrap.top", 64'hFFFF_FFFF_FFFF_FFFC);
        drive(0, 0, 0, 0);
        chk_addr("wrap.zero", 64'h0);
        chk_df("wrap.out", 64'hFFFF_FFFF_FFFF_FFFC, ifn(64'hFFFF_FFFF_FFFF_FFFC));

        // Random traffic against the program-order model.
        reset = 1'b1;
        drive(0, 0, 0, 0);
        reset   = 1'b0;
        want_pc = RST_PC;
        stale   = 1'b0;
        sb_q.delete();
        rnd_on  = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            bit          st;
            bit          br;
            bit          ok;
            logic [63:0] tgt;
            st = ($urandom_range(0, 99) < 30);
            br = ($urandom_range(0, 99) < 6);
            ok = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 7) == 0)
                tgt = {32'hFFFF_FFFF, 20'hF_FFFF, 10'($urandom_range(0, 1023)), 2'b00};
            else
                tgt = RST_PC + {50'd0, 12'($urandom_range(0, 4095)), 2'b00};
            drive(ok, st, br, tgt);
            model_step(br, tgt);
        end
        for (int n = 0; n < 12; n++) begin
            drive(0, 0, 0, 0);
            model_step(1'b0, 64'd0);
        end
        chk("drain.empty", 64'(sb_q.size()), 64'd0);
        rnd_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
